misc_wb: RTL

- Wishbone slave for SoC slot 0 (misc). Replaces the ad-hoc misc register logic.
- Sits directly upstream of dfu_helper, driving boot_now/boot_sel, and of led_blinker, driving led_ena/led_off/led_on.
- Adds a key-armed warm-boot request with auto-disarm timeout, a millisecond tick counter, and a debounced button status with a latched press flag.
- CPU side runs at 24 MHz.

---
 rtl/misc_wb.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/misc_wb.sv
// Wishbone slave for the misc slot: boot request with key arming, LED blinker
// settings, millisecond tick counter and a debounced button with press latch.
module misc_wb #(
  parameter int          TICK_DIV    = 24000,
  parameter int          DEBOUNCE_MS = 8,
  parameter int          ARM_TIMEOUT = 1000,
  parameter logic [31:0] BOOT_KEY    = 32'hB007CAFE
) (
  input  logic        clk_24m,
  input  logic        rst,
  input  logic [2:0]  wb_addr,
  input  logic [31:0] wb_wdata,
  output logic [31:0] wb_rdata,
  input  logic        wb_we,
  input  logic        wb_cyc,
  output logic        wb_ack,
  input  logic        btn_pad,
  output logic        boot_now,
  output logic [1:0]  boot_sel,
  output logic        led_ena,
  output logic [10:0] led_off,
  output logic [10:0] led_on
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int AW = $clog2(ARM_TIMEOUT + 1);

  localparam logic [2:0] ADDR_BOOT = 3'd0;
  localparam logic [2:0] ADDR_LED  = 3'd1;
  localparam logic [2:0] ADDR_ARM  = 3'd2;
  localparam logic [2:0] ADDR_TICK = 3'd3;
  localparam logic [2:0] ADDR_BTN  = 3'd4;

  logic          access;
  logic          wr;
  logic [31:0]   rd_mux;
  logic [PW-1:0] prescaler;
  logic          tick;
  logic [31:0]   ms_count;
  logic          armed;
  logic [AW-1:0] arm_timer;
  logic          btn_m;
  logic          btn_s;
  logic          btn_db;
  logic          press;
  logic [DW-1:0] db_count;
  logic          db_change;

  // Access is the single cycle in which ack gets raised; writes commit there.
  assign access    = wb_cyc & ~wb_ack;
  assign wr        = access & wb_we;
  assign tick      = (prescaler == PW'(TICK_DIV - 1));
  assign db_change = tick && (btn_s != btn_db) && (db_count == DW'(DEBOUNCE_MS - 1));

  always_comb begin
    rd_mux = '0;
    case (wb_addr)
      ADDR_BOOT: rd_mux = {28'b0, armed, boot_now, boot_sel};
      ADDR_LED:  rd_mux = {led_ena, 4'b0, led_off, 5'b0, led_on};
      ADDR_ARM:  rd_mux = {31'b0, armed};
      ADDR_TICK: rd_mux = ms_count;
      ADDR_BTN:  rd_mux = {30'b0, press, btn_db};
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
    end else begin
      wb_ack   <= access;
      wb_rdata <= access ? rd_mux : '0;
    end
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      boot_now <= 1'b0;
      boot_sel <= '0;
      led_ena  <= 1'b0;
      led_off  <= '0;
      led_on   <= '0;
    end else if (wr) begin
      if (wb_addr == ADDR_BOOT) begin
        boot_sel <= wb_wdata[1:0];
        if (wb_wdata[2] && armed) boot_now <= 1'b1;
      end
      if (wb_addr == ADDR_LED) begin
        led_ena <= wb_wdata[31];
        led_off <= wb_wdata[26:16];
        led_on  <= wb_wdata[10:0];
      end
    end
  end

  // A TICK write beats a coincident tick so the counter restarts cleanly at 0.
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      ms_count  <= '0;
    end else if (wr && wb_addr == ADDR_TICK) begin
      prescaler <= '0;
      ms_count  <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) ms_count <= ms_count + 1'b1;
    end
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      armed     <= 1'b0;
      arm_timer <= '0;
    end else if (wr && wb_addr == ADDR_ARM) begin
      armed     <= (wb_wdata == BOOT_KEY);
      arm_timer <= (wb_wdata == BOOT_KEY) ? AW'(ARM_TIMEOUT) : '0;
    end else if (armed && tick) begin
      if (arm_timer == AW'(1)) begin
        armed     <= 1'b0;
        arm_timer <= '0;
      end else begin
        arm_timer <= arm_timer - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      btn_m    <= 1'b0;
      btn_s    <= 1'b0;
      btn_db   <= 1'b0;
      db_count <= '0;
      press    <= 1'b0;
    end else begin
      btn_m <= btn_pad;
      btn_s <= btn_m;
      if (btn_s == btn_db) begin
        db_count <= '0;
      end else if (db_change) begin
        btn_db   <= btn_s;
        db_count <= '0;
      end else if (tick) begin
        db_count <= db_count + 1'b1;
      end
      // A rising debounced edge outranks a simultaneous W1C clear.
      if (db_change && btn_s) begin
        press <= 1'b1;
      end else if (wr && wb_addr == ADDR_BTN && wb_wdata[1]) begin
        press <= 1'b0;
      end
    end
  end

endmodule
